// File: rtl/am_insert_module.sv
// Alignment-marker inserter: passes coded blocks through with one cycle of latency
// and, once per N_BLOCKS period, emits an AM carrying lane id and BIP parity.
module am_insert_module #(
    parameter int LEN_CODED_BLOCK = 66,
    parameter int N_ALIGNER       = 20,
    parameter int NB_LANE_ID      = $clog2(N_ALIGNER),
    parameter int N_BLOCKS        = 16384
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_valid,
    input  logic [LEN_CODED_BLOCK-1:0] i_data,
    input  logic [NB_LANE_ID-1:0]      i_lane_id,
    output logic                       o_ready,
    output logic [LEN_CODED_BLOCK-1:0] o_data,
    output logic                       o_valid,
    output logic                       o_am_flag
);
    localparam int NB_CNT = $clog2(N_BLOCKS);

    // M0,M1,M2 per lane from IEEE 802.3 Table 82-2
    localparam logic [23:0] AM_TABLE [0:19] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    };

    typedef enum logic {INSERT_AM, DATA} state_t;

    state_t                     r_state, w_next_state;
    logic [NB_CNT-1:0]          r_cnt;
    logic [7:0]                 r_bip;
    logic [LEN_CODED_BLOCK-1:0] r_data;
    logic                       r_valid, r_am;
    logic                       w_xfer, w_lane_ok;
    logic [23:0]                w_m;
    logic [7:0]                 w_bip3;
    logic [LEN_CODED_BLOCK-1:0] w_am;

    // Bit j covers transmission bits 2+j+8k; lanes 3/4 also absorb the sync header
    function automatic logic [7:0] bip_of(input logic [LEN_CODED_BLOCK-1:0] b);
        logic [7:0] p;
        p = '0;
        for (int j = 0; j < 8; j++)
            for (int k = 0; k < 8; k++)
                p[j] = p[j] ^ b[63-j-8*k];
        p[3] = p[3] ^ b[65];
        p[4] = p[4] ^ b[64];
        return p;
    endfunction

    assign w_lane_ok = (int'(i_lane_id) < N_ALIGNER) && (int'(i_lane_id) < 20);
    assign w_m       = w_lane_ok ? AM_TABLE[i_lane_id] : AM_TABLE[0];
    // bip[0] is transmitted first, so it lands in the byte MSB
    assign w_bip3    = {<<{r_bip}};
    assign w_am      = {2'b10, w_m, w_bip3, ~w_m, ~w_bip3};

    always_comb begin
        w_next_state = r_state;
        o_ready      = 1'b0;
        w_xfer       = 1'b0;
        case (r_state)
            INSERT_AM: begin
                if (i_enable) w_next_state = DATA;
            end
            DATA: begin
                o_ready = i_enable;
                w_xfer  = i_enable && i_valid;
                if (w_xfer && (r_cnt == NB_CNT'(N_BLOCKS - 2))) w_next_state = INSERT_AM;
            end
            default: w_next_state = INSERT_AM;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= INSERT_AM;
            r_cnt   <= '0;
            r_bip   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_am    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_am    <= 1'b0;
            if (i_enable) begin
                r_state <= w_next_state;
                if (r_state == INSERT_AM) begin
                    r_data  <= w_am;
                    r_valid <= 1'b1;
                    r_am    <= 1'b1;
                    r_cnt   <= '0;
                    r_bip   <= bip_of(w_am);
                end else if (w_xfer) begin
                    r_data  <= i_data;
                    r_valid <= 1'b1;
                    r_cnt   <= r_cnt + 1'b1;
                    r_bip   <= r_bip ^ bip_of(i_data);
                end
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_am_flag = r_am;
endmodule

// File: doc/am_insert_module.md
AM_INSERT_MODULE -- requirements
Module: am_insert_module

Interface
REQ-001 SHALL have parameter LEN_CODED_BLOCK, default 66: coded block width.
REQ-002 SHALL have parameter N_ALIGNER, default 20: PCS lane count.
REQ-003 SHALL have parameter NB_LANE_ID, default $clog2(N_ALIGNER): lane id width.
REQ-004 SHALL have parameter N_BLOCKS, default 16384: AM period in blocks, AM included.
REQ-005 SHALL have port i_clock, input, 1: the single clock.
REQ-006 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port i_enable, input, 1: clock enable; low freezes all state.
REQ-008 SHALL have port i_valid, input, 1: i_data holds a block.
REQ-009 SHALL have port i_data, input, LEN_CODED_BLOCK: block, SH in [65:64], transmission bit t at i_data[65-t].
REQ-010 SHALL have port i_lane_id, input, NB_LANE_ID: lane whose AM is inserted.
REQ-011 SHALL have port o_ready, output, 1: upstream may transfer this cycle.
REQ-012 SHALL have port o_data, output, LEN_CODED_BLOCK: output block stream.
REQ-013 SHALL have port o_valid, output, 1: o_data updated this cycle.
REQ-014 SHALL have port o_am_flag, output, 1: current o_data is an inserted AM.

Function
REQ-015 Transfer SHALL occur when i_enable && i_valid && o_ready; a transferred block SHALL appear unchanged on o_data one cycle later with o_valid=1, o_am_flag=0.
REQ-016 FSM SHALL have two states: INSERT_AM (o_ready=0) and DATA (o_ready=i_enable).
REQ-017 INSERT_AM with i_enable=1 SHALL register the AM on o_data with o_valid=1 and o_am_flag=1, clear the block counter, and move to DATA; with i_enable=0 it SHALL remain in INSERT_AM.
REQ-018 DATA SHALL count transfers only; after N_BLOCKS-1 (16383) transfers it SHALL move to INSERT_AM on the next cycle; i_valid gaps SHALL NOT advance the counter.
REQ-019 The AM block SHALL be {2'b10, M0, M1, M2, BIP3, M4, M5, M6, BIP7}, with M0 in [63:56] and BIP7 in [7:0].
REQ-020 M4..M6 SHALL equal ~M0..~M2.
REQ-021 M0..M2 SHALL come from an internal IEEE 802.3 Table 82-2 ROM indexed by i_lane_id, sampled in the AM cycle.
REQ-022 Lane 0 SHALL be C1,68,21; lane 1 SHALL be 9D,71,8E.
REQ-023 Lane id >= N_ALIGNER SHALL use the lane 0 values.
REQ-024 BIP accumulator bit j SHALL be the XOR of bits t=2+j+8k (k=0..7) of every emitted block; bit 3 SHALL also XOR t=0, and bit 4 SHALL also XOR t=1.
REQ-025 BIP3 SHALL be the accumulator over all blocks emitted from the previous AM (inclusive) to the current AM (exclusive), and BIP7 SHALL be ~BIP3.
REQ-026 BIP3 bit j SHALL sit at o_data[39-j] (MSB=bip[0]).
REQ-027 In the AM cycle the accumulator SHALL reload with the parity of the AM just emitted; no data parity SHALL be added in that cycle (o_ready=0).
REQ-028 When no block is emitted, o_valid and o_am_flag SHALL be 0 and o_data SHALL hold its value.
REQ-029 i_enable=0 SHALL hold the FSM, counter, accumulator and o_data, and SHALL force o_valid=0 and o_ready=0.

Reset
REQ-030 When i_reset=1 at a clock edge, the FSM SHALL go to INSERT_AM and the counter and accumulator SHALL clear.
REQ-031 When i_reset=1 at a clock edge, o_data, o_valid and o_am_flag SHALL clear; o_ready SHALL read 0 while the FSM is in INSERT_AM.
REQ-032 Reset SHALL take priority over i_enable and SHALL abort any period in progress.
REQ-033 The first AM after reset SHALL carry BIP3=00 and BIP7=FF.

Verification
REQ-034 Scenario: release reset, i_enable=1, i_valid=1, lane 0 -> next cycle o_data={10,C1 68 21 00 3E 97 DE FF}, o_am_flag=1, and o_ready=0 during that insert cycle.
REQ-035 Scenario: then 16383 blocks {01,64'h0} -> each passes through with 1-cycle latency; o_ready drops for one cycle; AM={10,C1 68 21 18 3E 97 DE E7}.
REQ-036 Scenario: repeat the 16383-zero-block period -> the third AM again carries BIP3=18, BIP7=E7.
REQ-037 Scenario: 10-cycle i_valid gap mid-period -> o_valid=0 during the gap; AM still follows exactly 16383 transfers.
REQ-038 Scenario: i_enable=0 for 5 cycles while in INSERT_AM -> no output and o_data held; AM is emitted on the first cycle i_enable returns to 1.
REQ-039 Scenario: reset at block 9000 with lane id 1 -> next cycle o_data={10,9D 71 8E 00 62 8E 71 FF}.
